// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: bus layouts, widths and load-op encodings shared by the memory stage.
package mem_stage_pkg;
    typedef enum logic [2:0] {
        MEM_LDW  = 3'd0,
        MEM_LDB  = 3'd1,
        MEM_LDH  = 3'd2,
        MEM_LDBU = 3'd3,
        MEM_LDHU = 3'd4
    } mem_op_e;

    typedef struct packed {
        logic [2:0]  mem_op;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_t;

    typedef struct packed {
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_t;

    typedef struct packed {
        logic        fwd_we;
        logic        fwd_is_load;
        logic [4:0]  fwd_dest;
        logic [31:0] fwd_data;
    } ms_fwd_t;

    localparam int ES_TO_MS_BUS_WD = $bits(es_to_ms_t);
    localparam int MS_TO_WS_BUS_WD = $bits(ms_to_ws_t);
    localparam int MS_FWD_BUS_WD   = $bits(ms_fwd_t);
endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: selects and sign/zero-extends the addressed byte or halfword of a loaded word.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  mem_op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    output logic [31:0] data
);
    logic [7:0]  b;
    logic [15:0] h;

    assign b = addr_lo[1] ? (addr_lo[0] ? word[31:24] : word[23:16])
                          : (addr_lo[0] ? word[15:8]  : word[7:0]);
    // Halfword selection ignores addr_lo[0]; there is no misalignment trap here.
    assign h = addr_lo[1] ? word[31:16] : word[15:0];

    always_comb begin
        data = mem_op == MEM_LDB  ? {{24{b[7]}}, b}  :
               mem_op == MEM_LDH  ? {{16{h[15]}}, h} :
               mem_op == MEM_LDBU ? {24'b0, b}       :
               mem_op == MEM_LDHU ? {16'b0, h}       : word;
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage; captures one-cycle-latency SRAM read data, holds it across
// stalls, aligns loads and forwards the result to write-back and decode.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus,
    input  logic [31:0]                data_sram_rdata
);
    es_to_ms_t   ms_r;
    ms_to_ws_t   ws;
    ms_fwd_t     fwd;
    logic        ms_valid;
    logic        rdata_first;
    logic [31:0] rdata_buf;
    logic [31:0] mem_word;
    logic [31:0] load_data;
    logic [31:0] final_result;

    // SRAM latency is fixed, so the stage is always ready to go.
    assign ms_allowin     = !ms_valid || ws_allowin;
    assign ms_to_ws_valid = ms_valid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid    <= 1'b0;
            ms_r        <= '0;
            rdata_first <= 1'b0;
            rdata_buf   <= '0;
        end else begin
            if (ms_allowin) ms_valid <= es_to_ms_valid;
            if (es_to_ms_valid && ms_allowin) ms_r <= es_to_ms_bus;
            rdata_first <= es_to_ms_valid && ms_allowin;
            if (rdata_first) rdata_buf <= data_sram_rdata;
        end
    end

    // The live SRAM output is only trustworthy in the first cycle after the request.
    assign mem_word = rdata_first ? data_sram_rdata : rdata_buf;

    load_align u_align (
        .mem_op  (ms_r.mem_op),
        .addr_lo (ms_r.alu_result[1:0]),
        .word    (mem_word),
        .data    (load_data)
    );

    assign final_result = ms_r.res_from_mem ? load_data : ms_r.alu_result;

    assign ws = '{gr_we: ms_r.gr_we, dest: ms_r.dest, final_result: final_result, pc: ms_r.pc};
    assign fwd = '{fwd_we:      ms_valid && ms_r.gr_we && (ms_r.dest != 5'd0),
                   fwd_is_load: ms_valid && ms_r.res_from_mem,
                   fwd_dest:    ms_r.dest,
                   fwd_data:    final_result};

    assign ms_to_ws_bus = ws;
    assign ms_fwd_bus   = fwd;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scoreboard bench for mem_stage.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    es_to_ms_t   es_bus;
    logic        ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    ms_fwd_t     fwd;
    logic [31:0] data_sram_rdata;

    int passed = 0;
    int total  = 0;
    ms_to_ws_t q[$];

    always #5 clk = ~clk;

    mem_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .ws_allowin      (ws_allowin),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_bus),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_to_ws_bus    (ms_to_ws_bus),
        .ms_fwd_bus      (fwd),
        .data_sram_rdata (data_sram_rdata)
    );

    function automatic es_to_ms_t mk(input logic [2:0] op, input logic rfm, input logic we,
                                     input logic [4:0] d, input logic [31:0] alu, input logic [31:0] pc);
        mk = '{mem_op: op, res_from_mem: rfm, gr_we: we, dest: d, alu_result: alu, pc: pc};
    endfunction

    function automatic ms_to_ws_t ex(input logic we, input logic [4:0] d, input logic [31:0] res,
                                     input logic [31:0] pc);
        ex = '{gr_we: we, dest: d, final_result: res, pc: pc};
    endfunction

    task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input es_to_ms_t b, input ms_to_ws_t e);
        es_to_ms_valid = 1'b1;
        es_bus = b;
        q.push_back(e);
    endtask

    task automatic check_out(input string tag);
        @(negedge clk);
        chk({tag, "_valid"}, 70'(ms_to_ws_valid), 70'd1);
        if (q.size() == 0) begin
            total++;
            $error("FAIL %s observed=output expected=no_pending_entry", tag);
        end else begin
            chk(tag, ms_to_ws_bus, q[0]);
            if (ws_allowin) void'(q.pop_front());
        end
    endtask

    initial begin
        resetn = 1'b0;
        ws_allowin = 1'b1;
        es_to_ms_valid = 1'b0;
        es_bus = '0;
        data_sram_rdata = '0;
        @(negedge clk);
        chk("rst_allowin", 70'(ms_allowin), 70'd1);
        chk("rst_valid", 70'(ms_to_ws_valid), 70'd0);
        chk("rst_fwd_we", 70'(fwd.fwd_we), 70'd0);
        #2 resetn = 1'b1;
        cyc();
        // LD.B, byte 3 of 0x80FF_0000
        send(mk(MEM_LDB, 1, 1, 5'd3, 32'h0000_1003, 32'h100), ex(1, 5'd3, 32'hFFFF_FF80, 32'h100));
        @(negedge clk);
        chk("ldb_not_yet_valid", 70'(ms_to_ws_valid), 70'd0);
        cyc();
        es_to_ms_valid = 1'b0;
        data_sram_rdata = 32'h80FF_0000;
        check_out("ldb");
        chk("ldb_fwd_is_load", 70'(fwd.fwd_is_load), 70'd1);
        chk("ldb_fwd_data", 70'(fwd.fwd_data), 70'hFFFF_FF80);
        // LD.HU then LD.H back to back at address ...2
        cyc();
        send(mk(MEM_LDHU, 1, 1, 5'd4, 32'h0000_2002, 32'h200), ex(1, 5'd4, 32'h0000_BEEF, 32'h200));
        cyc();
        send(mk(MEM_LDH, 1, 1, 5'd4, 32'h0000_2002, 32'h204), ex(1, 5'd4, 32'hFFFF_BEEF, 32'h204));
        data_sram_rdata = 32'hBEEF_1234;
        check_out("ldhu");
        cyc();
        es_to_ms_valid = 1'b0;
        data_sram_rdata = 32'hBEEF_1234;
        check_out("ldh");
        // LD.W held across 4 stall cycles while SRAM output wanders
        cyc();
        send(mk(MEM_LDW, 1, 1, 5'd8, 32'h0000_3000, 32'h300), ex(1, 5'd8, 32'h1234_5678, 32'h300));
        cyc();
        es_to_ms_valid = 1'b0;
        ws_allowin = 1'b0;
        data_sram_rdata = 32'h1234_5678;
        check_out("stall0");
        chk("stall0_allowin", 70'(ms_allowin), 70'd0);
        for (int i = 1; i < 4; i++) begin
            cyc();
            data_sram_rdata = $urandom;
            check_out($sformatf("stall%0d", i));
            chk($sformatf("stall%0d_allowin", i), 70'(ms_allowin), 70'd0);
        end
        cyc();
        ws_allowin = 1'b1;
        data_sram_rdata = $urandom;
        check_out("stall_release");
        chk("stall_release_allowin", 70'(ms_allowin), 70'd1);
        // ALU result to r5 followed by LD.BU
        cyc();
        send(mk(MEM_LDW, 0, 1, 5'd5, 32'd7, 32'h400), ex(1, 5'd5, 32'd7, 32'h400));
        cyc();
        send(mk(MEM_LDBU, 1, 1, 5'd6, 32'h0000_5001, 32'h404), ex(1, 5'd6, 32'h0000_00A5, 32'h404));
        data_sram_rdata = 32'hDEAD_DEAD;
        check_out("alu");
        chk("alu_fwd_we", 70'(fwd.fwd_we), 70'd1);
        chk("alu_fwd_dest", 70'(fwd.fwd_dest), 70'd5);
        chk("alu_fwd_is_load", 70'(fwd.fwd_is_load), 70'd0);
        cyc();
        es_to_ms_valid = 1'b0;
        data_sram_rdata = 32'h0000_A500;
        check_out("ldbu");
        chk("ldbu_fwd_is_load", 70'(fwd.fwd_is_load), 70'd1);
        // write to r0 must not forward
        cyc();
        send(mk(MEM_LDW, 0, 1, 5'd0, 32'h99, 32'h500), ex(1, 5'd0, 32'h99, 32'h500));
        cyc();
        es_to_ms_valid = 1'b0;
        check_out("r0");
        chk("r0_fwd_we", 70'(fwd.fwd_we), 70'd0);
        // asynchronous reset in the middle of a stall
        cyc();
        send(mk(MEM_LDW, 1, 1, 5'd9, 32'h0000_0600, 32'h600), ex(1, 5'd9, 32'hCAFE_F00D, 32'h600));
        cyc();
        es_to_ms_valid = 1'b0;
        ws_allowin = 1'b0;
        data_sram_rdata = 32'hCAFE_F00D;
        check_out("pre_reset");
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_valid", 70'(ms_to_ws_valid), 70'd0);
        chk("async_rst_allowin", 70'(ms_allowin), 70'd1);
        chk("async_rst_fwd_we", 70'(fwd.fwd_we), 70'd0);
        q.delete();
        #1 resetn = 1'b1;
        cyc();
        ws_allowin = 1'b1;
        send(mk(MEM_LDBU, 1, 1, 5'd7, 32'h0000_7002, 32'h700), ex(1, 5'd7, 32'h0000_00C3, 32'h700));
        cyc();
        es_to_ms_valid = 1'b0;
        data_sram_rdata = 32'h00C3_0000;
        check_out("post_reset");
        chk("queue_drained", 70'(q.size()), 70'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
